mux_sel_arbiter: RTL and testbench

- Upstream control stage for the 4-to-1 8-bit byte multiplexer.
- Arbitrates four byte-source request lines round-robin and drives the multiplexer's 2-bit select.
- Waits a programmable settle time, captures the multiplexer's 8-bit output into a register and presents it downstream on a valid/ready handshake.
- Acknowledges the served source with a one-cycle pulse.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 39 +++
 rtl/mux_sel_arbiter.sv | 118 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the byte-mux select arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;
  // Width of the settle down-counter; SETTLE must fit (0..15).
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  // One-hot decode of a source index.
  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode of the request lines.
// FIXED_PRIORITY_EN selects plain lowest-index-wins priority instead of round-robin.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

`ifdef FIXED_PRIORITY_EN
  logic unused_last;
  assign unused_last = ^last;

  // Scan from the top so source 0 is written last and wins.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = SEL_W'(i);
    end
  end
`else
  logic [SEL_W-1:0] cand;

  // Offset 1 from last is highest priority, so it is evaluated last; offset 4 wraps to last itself.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end
`endif

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select arbiter for the 4-to-1 byte mux: grants a source, waits SETTLE cycles,
// captures the mux output and hands it downstream on valid/ready.
// Optional macro FIXED_PRIORITY_EN: source 0 always has highest priority.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  req,
  input  logic [DWIDTH-1:0]   mux_in,
  output logic [SEL_W-1:0]    sel2,
  output logic [NUM_SRC-1:0]  gnt,
  output logic [NUM_SRC-1:0]  ack,
  output logic [DWIDTH-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [SEL_W-1:0]     sel2_d;
  logic [NUM_SRC-1:0]   gnt_d;
  logic [NUM_SRC-1:0]   ack_d;
  logic [DWIDTH-1:0]    data_d;
  logic                 valid_d;

  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_any;

  rr_pick u_pick (
    .req  (req),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel2_d  = sel2;
    gnt_d   = gnt;
    ack_d   = '0;
    data_d  = out_data;
    valid_d = out_valid;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          sel2_d  = pick_idx;
          gnt_d   = onehot(pick_idx);
          cnt_d   = SETTLE_CNT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        data_d  = mux_in;
        valid_d = 1'b1;
        ack_d   = onehot(sel2);
        last_d  = sel2;
        gnt_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          // last_q already holds the source just served, so it ranks lowest here.
          if (pick_any) begin
            sel2_d  = pick_idx;
            gnt_d   = onehot(pick_idx);
            cnt_d   = SETTLE_CNT;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any capture in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_W'(NUM_SRC - 1);
      sel2      <= '0;
      gnt       <= '0;
      ack       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel2      <= sel2_d;
      gnt       <= gnt_d;
      ack       <= ack_d;
      out_data  <= data_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with a scoreboard of expected (ack, byte) pairs.
module tb_mux_sel_arbiter;
  import mux_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req0;
  logic       out_ready, out_ready0;
  logic [7:0] mux_in, mux_in0;
  logic [1:0] sel2, sel2_0;
  logic [3:0] gnt, gnt0, ack, ack0;
  logic [7:0] out_data, out_data0;
  logic       out_valid, out_valid0;

  logic [7:0] tab [4];

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         ack_cnt = 0;
  int         xfer_cnt = 0;
  logic [1:0] model_last;

  always #5 clk = ~clk;

  // Behavioural model of the byte multiplexer feeding each DUT.
  assign mux_in  = tab[sel2];
  assign mux_in0 = tab[sel2_0];

  mux_sel_arbiter #(.DWIDTH(8), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mux_in    (mux_in),
    .sel2      (sel2),
    .gnt       (gnt),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_sel_arbiter #(.DWIDTH(8), .SETTLE(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req       (req0),
    .mux_in    (mux_in0),
    .sel2      (sel2_0),
    .gnt       (gnt0),
    .ack       (ack0),
    .out_data  (out_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] c;
`ifdef FIXED_PRIORITY_EN
    c = l;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return 2'(i);
    end
`else
    for (int k = 1; k <= 4; k++) begin
      c = l + 2'(k);
      if (r[c]) return c;
    end
`endif
    return c;
  endfunction

  // Push the expected results of n services while r is held.
  task automatic expect_service(input logic [3:0] r, input int n);
    exp_t       e;
    logic [1:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = model_pick(r, model_last);
      e.ack = 4'b0001 << idx;
      e.data = tab[idx];
      exp_q.push_back(e);
      model_last = idx;
    end
  endtask

  task automatic wait_acks(input int target);
    int cyc = 0;
    while (ack_cnt < target && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("ack_count", ack_cnt, target);
  endtask

  // Scoreboard: every ack pulse must match the next expected service.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack !== 4'b0000) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", ack, 4'b0000);
      end else begin
        e = exp_q.pop_front();
        check("sb_ack", ack, e.ack);
        check("sb_data", out_data, e.data);
        check("sb_valid", out_valid, 1'b1);
      end
    end
  end

  // Handshake counter, sampled with pre-edge values.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) xfer_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    req = '0;
    req0 = '0;
    out_ready = 1'b1;
    out_ready0 = 1'b1;
    tab[0] = 8'hA5; tab[1] = 8'h00; tab[2] = 8'h00; tab[3] = 8'h00;
    model_last = 2'd3;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel2", sel2, 2'd0);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_data", out_data, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_state", dut.state_q, S_IDLE);
    check("rst_cnt", dut.cnt_q, 4'd0);
    check("rst_last", dut.last_q, 2'd3);
    @(negedge clk);
    rst = 1'b0;

    // Single request, latency SETTLE+2 after the grant edge.
    @(negedge clk);
    req = 4'b0001;
    expect_service(4'b0001, 1);
    @(posedge clk); #1;
    check("t1_gnt", gnt, 4'b0001);
    check("t1_sel2", sel2, 2'd0);
    check("t1_valid_n1", out_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_n2", out_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_n3", out_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_n4", out_valid, 1'b1);
    check("t1_data", out_data, 8'hA5);
    check("t1_ack", ack, 4'b0001);
    check("t1_gnt_clr", gnt, 4'b0000);
    req = 4'b0000;
    @(posedge clk); #1;
    check("t1_ack_pulse", ack, 4'b0000);
    check("t1_valid_clr", out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_idle", dut.state_q, S_IDLE);
    check("t1_sel2_hold", sel2, 2'd0);

    // All four sources held: rotating service order.
    tab[0] = 8'h11; tab[1] = 8'h22; tab[2] = 8'h33; tab[3] = 8'h44;
    @(negedge clk);
    req = 4'b1111;
    base = ack_cnt;
    expect_service(4'b1111, 5);
    wait_acks(base + 5);
    req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    check("rr_sb_empty", exp_q.size(), 0);
    check("rr_idle", dut.state_q, S_IDLE);

    // Downstream stall: output frozen, requests ignored until the handshake.
    @(negedge clk);
    out_ready = 1'b0;
    req = 4'b0010;
    expect_service(4'b0010, 1);
    base = ack_cnt;
    wait_acks(base + 1);
    base = xfer_cnt;
    req = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, tab[1]);
      check("hold_gnt", gnt, 4'b0000);
      check("hold_state", dut.state_q, S_HOLD);
      req = 4'($urandom_range(1, 15));
    end
    @(negedge clk);
    req = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", out_valid, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("hold_one_xfer", xfer_cnt, base + 1);
    check("hold_no_gnt", gnt, 4'b0000);

    // Asynchronous reset during SETTLE discards the pending capture.
    @(negedge clk);
    req = 4'b1000;
    @(posedge clk); #1;
    check("rs_gnt", gnt, 4'b1000);
    check("rs_state", dut.state_q, S_SETTLE);
    #2;
    rst = 1'b1;
    #1;
    check("rs_sel2", sel2, 2'd0);
    check("rs_gnt0", gnt, 4'b0000);
    check("rs_data", out_data, 8'h00);
    check("rs_valid", out_valid, 1'b0);
    check("rs_state_idle", dut.state_q, S_IDLE);
    model_last = 2'd3;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    expect_service(4'b1001, 1);
    @(posedge clk); #1;
    check("rs_first_gnt", gnt, 4'b0001);
    base = ack_cnt;
    wait_acks(base + 1);
    req = 4'b0000;
    repeat (4) @(posedge clk);

    // Two contenders held: alternation (or source 0 only with fixed priority).
    @(negedge clk);
    req = 4'b0011;
    base = ack_cnt;
    expect_service(4'b0011, 4);
    wait_acks(base + 4);
    req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    check("pair_sb_empty", exp_q.size(), 0);

    // SETTLE=0 instance, single requester re-served each round.
    @(negedge clk);
    req0 = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (k == 0) check("s0_gnt", gnt0, 4'b0100);
      check("s0_ack", ack0, (k % 3 == 2) ? 4'b0100 : 4'b0000);
      if (k % 3 == 2) check("s0_data", out_data0, tab[2]);
    end
    req0 = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    check("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
